// File: rtl/sel_pkg.sv
// Shared definitions for the channel-select scanner: select width and debounce states.
package sel_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } deb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debounce FSM for a raw push-button.
// `rise` is a combinational one-cycle pulse in the cycle a press is accepted.
module btn_debounce
    import sel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1;
    logic             s;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;

    // Metastability guard on the asynchronous button input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end

    // A level is accepted once the synchronized input has differed from it
    // for DEBOUNCE_CYC+1 consecutive samples; any glitch back restarts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        rise      = 1'b0;
        case (state)
            IDLE_LO: begin
                if (s) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYC)) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    rise      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYC)) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sel_step_scanner.sv
// Channel select generator for the 4-to-1 mux: debounced button steps merged
// with an optional fixed-dwell auto-scan.
module sel_step_scanner
    import sel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned SCAN_DIV     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             auto_en,
    output logic [SEL_W-1:0] sel,
    output logic             sel_chg,
    output logic             deb_level
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             step_btn;
    logic             step_auto;
    logic             step;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_step),
        .level (deb_level),
        .rise  (step_btn)
    );

    assign step_auto = auto_en && (div == DIV_W'(SCAN_DIV - 1));
    assign step      = step_btn | step_auto;

    // Any step restarts the dwell, so a button press during auto-scan
    // pushes the next automatic step a full dwell out.
    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            sel     <= '0;
            sel_chg <= 1'b0;
        end else begin
            sel_chg <= step;
            if (step) begin
                sel <= sel + SEL_W'(1);
            end
            if (step || !auto_en) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sel_step_scanner.sv
// Self-checking bench for sel_step_scanner: directed timing checks plus
// randomized button/auto-scan traffic against a behavioural model.
module tb_sel_step_scanner;

    localparam int unsigned DEB = 4;
    localparam int unsigned SDIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_step = 1'b1;
    logic       auto_en = 1'b1;
    logic [1:0] sel;
    logic       sel_chg;
    logic       deb_level;

    int checks = 0;
    int errors = 0;

    sel_step_scanner #(
        .DEBOUNCE_CYC (DEB),
        .SCAN_DIV     (SDIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .auto_en   (auto_en),
        .sel       (sel),
        .sel_chg   (sel_chg),
        .deb_level (deb_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: button samples travel through a 2-deep history;
    // a level flips after DEB+1 consecutive disagreeing samples; auto-scan
    // fires after SDIV enabled cycles since the last step.
    bit     mv = 1'b0;
    bit     hist [2];
    bit     m_lvl;
    int     m_run;
    int     m_dwell;
    int     m_sel;
    bit     m_chg;

    always @(posedge clk) begin
        bit s_now;
        bit press;
        bit auto_fire;
        if (rst) begin
            hist[0] = 1'b0;
            hist[1] = 1'b0;
            m_lvl   = 1'b0;
            m_run   = 0;
            m_dwell = 0;
            m_sel   = 0;
            m_chg   = 1'b0;
            mv      = 1'b1;
        end else begin
            s_now = hist[1];
            press = 1'b0;
            if (s_now != m_lvl) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl = s_now;
                    m_run = 0;
                    press = s_now;
                end
            end else begin
                m_run = 0;
            end
            auto_fire = 1'b0;
            if (auto_en) begin
                m_dwell++;
                auto_fire = (m_dwell == SDIV);
            end
            m_chg = press | auto_fire;
            if (m_chg) begin
                m_sel   = (m_sel + 1) % 4;
                m_dwell = 0;
            end else if (!auto_en) begin
                m_dwell = 0;
            end
            hist[1] = hist[0];
            hist[0] = btn_step;
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            check("model_sel", int'(sel), m_sel);
            check("model_sel_chg", int'(sel_chg), int'(m_chg));
            check("model_deb_level", int'(deb_level), int'(m_lvl));
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        btn_step = 1'b0;
        auto_en  = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(3);
    endtask

    initial begin
        int pulses;
        int len;

        // Reset held with button and auto-scan active.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_sel", int'(sel), 0);
            check("rst_sel_chg", int'(sel_chg), 0);
            check("rst_deb_level", int'(deb_level), 0);
        end

        // Clean press and release.
        do_reset();
        btn_step = 1'b1;
        tick(6);
        check("press_sel_early", int'(sel), 0);
        check("press_deb_early", int'(deb_level), 0);
        tick(1);
        check("press_sel", int'(sel), 1);
        check("press_deb", int'(deb_level), 1);
        check("press_chg", int'(sel_chg), 1);
        tick(1);
        check("press_chg_drop", int'(sel_chg), 0);
        tick(12);
        btn_step = 1'b0;
        tick(6);
        check("release_deb_early", int'(deb_level), 1);
        tick(1);
        check("release_deb", int'(deb_level), 0);
        check("release_sel", int'(sel), 1);
        tick(4);

        // Short bounce, then four clean presses wrapping the select.
        do_reset();
        btn_step = 1'b1;
        tick(3);
        btn_step = 1'b0;
        tick(15);
        check("bounce_sel", int'(sel), 0);
        check("bounce_deb", int'(deb_level), 0);
        for (int i = 0; i < 4; i++) begin
            pulses   = 0;
            btn_step = 1'b1;
            for (int c = 0; c < 8; c++) begin
                tick(1);
                pulses += int'(sel_chg);
            end
            btn_step = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick(1);
                pulses += int'(sel_chg);
            end
            check("wrap_sel", int'(sel), (i + 1) % 4);
            check("wrap_pulses", pulses, 1);
        end

        // Auto-scan stepping and mid-dwell disable.
        do_reset();
        auto_en = 1'b1;
        tick(7);
        check("auto_sel0", int'(sel), 0);
        tick(1);
        check("auto_sel1", int'(sel), 1);
        check("auto_chg1", int'(sel_chg), 1);
        tick(8);
        check("auto_sel2", int'(sel), 2);
        tick(8);
        check("auto_sel3", int'(sel), 3);
        tick(1);
        auto_en = 1'b0;
        tick(20);
        check("auto_hold", int'(sel), 3);

        // Button press lands on the auto terminal count.
        do_reset();
        auto_en = 1'b1;
        tick(9);
        btn_step = 1'b1;
        tick(6);
        check("coll_pre", int'(sel), 1);
        tick(1);
        check("coll_sel", int'(sel), 2);
        check("coll_chg", int'(sel_chg), 1);
        tick(1);
        check("coll_chg_drop", int'(sel_chg), 0);
        tick(6);
        check("coll_dwell_early", int'(sel), 2);
        tick(1);
        check("coll_next_auto", int'(sel), 3);
        btn_step = 1'b0;
        auto_en  = 1'b0;
        tick(12);

        // Reset while debouncing a held button.
        do_reset();
        btn_step = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("mid_rst_sel", int'(sel), 0);
        check("mid_rst_deb", int'(deb_level), 0);
        rst = 1'b0;
        tick(6);
        check("mid_rst_early", int'(sel), 0);
        tick(1);
        check("mid_rst_sel1", int'(sel), 1);
        check("mid_rst_deb1", int'(deb_level), 1);
        btn_step = 1'b0;
        tick(10);

        // Randomized traffic with bounces, auto toggles and occasional reset.
        for (int seg = 0; seg < 300; seg++) begin
            btn_step = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(5, 14));
            if ($urandom_range(0, 9) == 0) auto_en = ~auto_en;
            rst = ($urandom_range(0, 60) == 0);
            tick(1);
            rst = 1'b0;
            if (len > 1) tick(len - 1);
        end
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sel_step_scanner.md
# sel_step_scanner

Upstream select generator for the 4-to-1 channel mux on the NVBoard path. Turns a raw, bouncy push-button into a clean 2-bit select that advances one channel per press, with an optional auto-scan mode that steps through the channels on a fixed dwell. The output `sel` drives the mux select input directly. `sel_chg` flags every select update for the downstream display logic.

## Interface
- `DEBOUNCE_CYC`, default 16: consecutive stable synchronized samples required to accept a button level; legal range ≥2.
- `SCAN_DIV`, default 1024: cycles per channel in auto-scan; legal range ≥2.
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_step`  in  1  raw asynchronous push-button, high = pressed.
- `auto_en`  in  1  auto-scan enable, synchronous level.
- `sel`  out  2  registered channel select to the mux; reset 2'b00.
- `sel_chg`  out  1  registered one-cycle pulse in the cycle `sel` takes a new value; reset 0.
- `deb_level`  out  1  registered debounced button level, for the LED; reset 0.

## Operation
- Synchronizer: `btn_step` passes through two flops giving `s`. Both flops reset to 0.
- Debounce FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. The counter `cnt` is ceil(log2(DEBOUNCE_CYC+1)) bits.
  - IDLE_LO: if `s`=1, go to WAIT_HI with `cnt`=1.
  - WAIT_HI: if `s`=0, return to IDLE_LO with `cnt`=0. Otherwise, if `cnt`=DEBOUNCE_CYC, go to IDLE_HI, set `deb_level`=1 and raise `step_btn`. Otherwise increment `cnt`.
  - IDLE_HI and WAIT_LO mirror the above for release. Release raises no step and clears `deb_level`.
- Auto-scan: a divider `div` counts while `auto_en`=1. When `div`=SCAN_DIV-1, raise `step_auto` and set `div`=0. While `auto_en`=0, `div` is held at 0.
- Step merge: `step` = `step_btn` | `step_auto`.
  - On `step`, `sel` ← `sel`+1 modulo 4 (3 wraps to 0), `sel_chg`=1, and `div` clears.
  - Simultaneous button and auto steps advance `sel` by exactly 1.
- Auto-scan has no effect on the debounce FSM. The button works in both modes.
- Deasserting `auto_en` mid-dwell holds `sel` and discards partial dwell.

## Timing
- Button latency: raw high first sampled at edge k and held stable. Then `s`=1 after edge k+1, and `sel` and `deb_level` update at edge k+DEBOUNCE_CYC+2. `sel_chg` is high for exactly that one cycle.
- Release latency: same path count. `deb_level` falls at edge k+DEBOUNCE_CYC+2 after release is first sampled. `sel` is unchanged.
- A bounce shorter than DEBOUNCE_CYC synchronized cycles produces no output change.
- Auto latency: with `auto_en` first sampled high at edge a, `sel` steps at edges a+SCAN_DIV-1, then every SCAN_DIV cycles.
- Button step during auto-scan restarts the dwell: the next auto step comes SCAN_DIV cycles after the button step.
- Reset mid-operation: at the next edge all state returns to reset values (FSM IDLE_LO, `cnt`=0, `div`=0, sync flops 0, outputs as listed).
  - A button still held after reset is re-debounced fully and counts as a new press.

## Structure
- Shared package `sel_pkg`:
  - `SEL_W`=2.
  - Debounce state enum `deb_state_t` {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO}.
- Sub-module `btn_debounce` (parameter DEBOUNCE_CYC):
  - Ports `clk`, `rst`, raw in, `level` out, `rise` pulse out.
  - Contains the synchronizer, FSM and `cnt`.
- Top level holds the divider, step merge and `sel`/`sel_chg` registers.

## Test plan
- Reset: DEBOUNCE_CYC=4, SCAN_DIV=8. `rst`=1 for 3 cycles with `btn_step`=1 and `auto_en`=1 → `sel`=0, `sel_chg`=0, `deb_level`=0 in every reset cycle.
- Clean press: raw high from edge 10 for 20 cycles → `sel` 0→1 and `deb_level`=1 at edge 16; `sel_chg` high exactly one cycle; release → `deb_level`=0 at edge 36, `sel` stays 1.
- Bounce and wrap: raw high 3 cycles then low → no change. Then 4 clean presses → `sel` 1,2,3,0 with four single-cycle `sel_chg` pulses.
- Auto-scan: `auto_en`=1 from edge 5 → `sel` steps at edges 12, 20, 28, 36 (1,2,3,0). Drop `auto_en` at edge 30 → `sel` holds 3.
- Collision: align a debounced press with auto terminal count → `sel` +1 only, one `sel_chg`, next auto step 8 cycles later.
- Reset mid-debounce: `rst` in WAIT_HI with `cnt`=2 and button held → `sel`=0. After release of `rst`, `sel`=1 comes exactly DEBOUNCE_CYC+2 edges after `s` is re-sampled.
